// File: rtl/bit_diff_sched_if.sv
// Interface: bit_diff_sched_if
// Purpose : Client-side handshake bundle for the bit_diff scheduler. Carries
//           the per-requester job requests and the shared response channel.
// Signals : req_valid  [NUM_REQ]        job request per requester
//           req_data   [NUM_REQ*WIDTH]  job data, requester i at [i*WIDTH +: WIDTH]
//           req_ready  [NUM_REQ]        one-hot accept pulse from the scheduler
//           rsp_valid                   response available
//           rsp_ready                   response consumer accept
//           rsp_id     [IDW]            requester index of the response
//           rsp_result [RW]             signed ones-minus-zeros result
//           rsp_err                     watchdog abort flag
// Modports: master = requester/consumer side, slave = scheduler side.
interface bit_diff_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int RW  = $clog2(2 * WIDTH + 1);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic signed [RW-1:0]     rsp_result;
    logic                     rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/bit_diff_sched.sv
// Module : bit_diff_sched
// Purpose: Round-robin scheduler sharing one bit_diff unit among NUM_REQ
//          requesters. One job in flight; the result (ones - zeros) is
//          returned with the requester id, or an error if the unit hangs.
// Ports  : clk        clock, rising edge
//          rst        asynchronous active-low reset
//          bus        bit_diff_sched_if.slave (requests + response channel)
//          bd_go      one-cycle start pulse to the unit
//          bd_data    job data to the unit, held from ISSUE through RESP
//          bd_result  signed unit result
//          bd_done    unit done level
//          busy       high in every state except IDLE
module bit_diff_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int RW     = $clog2(2 * WIDTH + 1),
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_diff_sched_if.slave      bus,
    output logic                 bd_go,
    output logic [WIDTH-1:0]     bd_data,
    input  logic signed [RW-1:0] bd_result,
    input  logic                 bd_done,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       id_q;
    logic [WIDTH-1:0]     data_q;
    logic signed [RW-1:0] result_q;
    logic                 err_q;
    logic [CW-1:0]        wd_cnt;
    logic                 wd_expired;
    logic                 grant_found;
    logic [IDW-1:0]       grant_id;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic                 rsp_valid_c;
    int                   idx;

    assign wd_expired     = (wd_cnt == CW'(TIMEOUT - 1));
    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;
    assign bd_data        = data_q;
    assign busy           = (state != IDLE);

    // Search from rr_ptr upward with wrap-around; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // req_ready is gated by rst so that a request raised while the
    // scheduler is held in reset is never acknowledged.
    always_comb begin
        next_state  = state;
        req_ready_c = '0;
        rsp_valid_c = 1'b0;
        bd_go       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && rst) begin
                    req_ready_c[grant_id] = 1'b1;
                    next_state            = ISSUE;
                end
            end
            ISSUE: begin
                bd_go      = 1'b1;
                next_state = SETTLE;
            end
            // bd_done may still show the previous job here, so it is ignored.
            SETTLE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (bd_done || wd_expired) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Job latch, round-robin pointer, watchdog and response capture.
    // A real done wins over a watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        data_q   <= bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
                        id_q     <= grant_id;
                        rr_ptr   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                        result_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                SETTLE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (bd_done) begin
                        result_q <= bd_result;
                        err_q    <= 1'b0;
                    end else if (wd_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
